icebus_motor_responder: RTL

- Motor-board end of the single-wire-pair UART link driven by the FPGA-side motor com block.
- Receives setpoint command frames addressed to its motor ID and latches the setpoint.
- Answers each accepted command with one status frame: position, velocity, displacement, current.
- Contains its own 8N1 UART receiver and transmitter, plus the frame parser and frame builder.

---
 rtl/icebus_motor_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/icebus_motor_responder.sv
// rtl/icebus_motor_responder.sv - motor-side UART command responder (optional feature macro: ICEBUS_RESPONDER_TIMEOUT_EN)
module icebus_motor_responder #(
    parameter int unsigned CLOCK_SPEED_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE      = 1_000_000,
    parameter logic [7:0]  MOTOR_ID       = 8'd0,
    parameter int unsigned TIMEOUT_CLKS   = 20 * (CLOCK_SPEED_HZ / BAUD_RATE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx,
    output logic               tx,
    input  logic signed [31:0] position,
    input  logic signed [31:0] velocity,
    input  logic signed [31:0] displacement,
    input  logic signed [15:0] current,
    output logic signed [31:0] setpoint,
    output logic               setpoint_valid,
    output logic               frame_error,
    output logic               busy
);
    localparam int unsigned CLKS_PER_BIT = CLOCK_SPEED_HZ / BAUD_RATE;
    localparam logic [15:0] BIT_LAST      = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST     = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CLKS);
`ifdef ICEBUS_RESPONDER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ID, P_DATA0, P_DATA1, P_DATA2, P_DATA3, P_CHK} p_state_t;

    logic         rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t    rx_state_q, rx_state_d;
    logic [15:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]   rx_bit_q, rx_bit_d;
    logic [7:0]   rx_shift_q, rx_shift_d;
    logic         rx_done_q, rx_done_d;
    logic         rx_ok_q, rx_ok_d;
    logic [7:0]   rx_byte_q, rx_byte_d;

    p_state_t     p_state_q, p_state_d;
    logic [7:0]   p_id_q, p_id_d;
    logic [7:0]   p_sum_q, p_sum_d;
    logic [31:0]  p_sp_q, p_sp_d;
    logic [31:0]  to_cnt_q, to_cnt_d;
    logic         accept, ferr;

    logic [31:0]  setpoint_q;
    logic         setpoint_valid_q, frame_error_q;
    logic         pending_q;
    logic [111:0] snap_q;

    tx_state_t    tx_state_q, tx_state_d;
    logic [15:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]   tx_bit_q, tx_bit_d;
    logic [7:0]   tx_shift_q, tx_shift_d;
    logic [4:0]   tx_idx_q, tx_idx_d;
    logic [111:0] tx_buf_q, tx_buf_d;
    logic [7:0]   tx_sum_q, tx_sum_d;
    logic         tx_q, tx_d;
    logic         take_pending;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // UART receiver: confirm start at half bit, sample data and stop at mid-bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_d  = 1'b0;
        rx_ok_d    = 1'b0;
        rx_byte_d  = rx_byte_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_done_d  = 1'b1;
                    rx_ok_d    = rx_sync_q;
                    rx_byte_d  = rx_shift_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver state register
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_done_q  <= 1'b0;
            rx_ok_q    <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_done_q  <= rx_done_d;
            rx_ok_q    <= rx_ok_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    // Inter-byte idle counter; only runs mid-frame while the line is quiet
    always_comb begin
        to_cnt_d = '0;
        if (TIMEOUT_EN && p_state_q != P_IDLE && rx_state_q == RX_IDLE && !rx_done_q
            && to_cnt_q != TIMEOUT_LIMIT)
            to_cnt_d = to_cnt_q + 32'd1;
    end

    // Command parser: walks the 7-byte frame, checks sum and ID in CHK
    always_comb begin
        p_state_d = p_state_q;
        p_id_d    = p_id_q;
        p_sum_d   = p_sum_q;
        p_sp_d    = p_sp_q;
        accept    = 1'b0;
        ferr      = 1'b0;
        if (rx_done_q && !rx_ok_q) begin
            ferr      = 1'b1;
            p_state_d = P_IDLE;
        end else if (rx_done_q) begin
            unique case (p_state_q)
                P_IDLE:  if (rx_byte_q == 8'h55) p_state_d = P_ID;
                P_ID: begin
                    p_id_d    = rx_byte_q;
                    p_sum_d   = rx_byte_q;
                    p_state_d = P_DATA0;
                end
                P_DATA0: begin
                    p_sp_d[7:0] = rx_byte_q;
                    p_sum_d     = p_sum_q + rx_byte_q;
                    p_state_d   = P_DATA1;
                end
                P_DATA1: begin
                    p_sp_d[15:8] = rx_byte_q;
                    p_sum_d      = p_sum_q + rx_byte_q;
                    p_state_d    = P_DATA2;
                end
                P_DATA2: begin
                    p_sp_d[23:16] = rx_byte_q;
                    p_sum_d       = p_sum_q + rx_byte_q;
                    p_state_d     = P_DATA3;
                end
                P_DATA3: begin
                    p_sp_d[31:24] = rx_byte_q;
                    p_sum_d       = p_sum_q + rx_byte_q;
                    p_state_d     = P_CHK;
                end
                P_CHK: begin
                    p_state_d = P_IDLE;
                    if (rx_byte_q != p_sum_q) ferr = 1'b1;
                    else if (p_id_q == MOTOR_ID) accept = 1'b1;
                end
                default: p_state_d = P_IDLE;
            endcase
        end else if (TIMEOUT_EN && p_state_q != P_IDLE && to_cnt_q == TIMEOUT_LIMIT) begin
            ferr      = 1'b1;
            p_state_d = P_IDLE;
        end
    end

    // Parser state register
    always_ff @(posedge clock) begin
        if (reset) begin
            p_state_q <= P_IDLE;
            p_id_q    <= '0;
            p_sum_q   <= '0;
            p_sp_q    <= '0;
            to_cnt_q  <= '0;
        end else begin
            p_state_q <= p_state_d;
            p_id_q    <= p_id_d;
            p_sum_q   <= p_sum_d;
            p_sp_q    <= p_sp_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Setpoint latch, status snapshot and the one-deep pending flag
    always_ff @(posedge clock) begin
        if (reset) begin
            setpoint_q       <= '0;
            setpoint_valid_q <= 1'b0;
            frame_error_q    <= 1'b0;
            pending_q        <= 1'b0;
            snap_q           <= '0;
        end else begin
            setpoint_valid_q <= accept;
            frame_error_q    <= ferr;
            if (accept) begin
                setpoint_q <= p_sp_q;
                snap_q     <= {current, displacement, velocity, position};
                pending_q  <= 1'b1;
            end else if (take_pending) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Transmitter: copies the snapshot at frame start so later commands cannot corrupt it
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q + 16'd1;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_idx_d     = tx_idx_q;
        tx_buf_d     = tx_buf_q;
        tx_sum_d     = tx_sum_q;
        tx_d         = tx_q;
        take_pending = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (pending_q) begin
                    take_pending = 1'b1;
                    tx_buf_d     = snap_q;
                    tx_sum_d     = MOTOR_ID;
                    tx_idx_d     = '0;
                    tx_shift_d   = 8'hAA;
                    tx_state_d   = TX_START;
                    tx_d         = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_d = tx_shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 5'd16) begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 5'd1;
                        tx_state_d = TX_START;
                        tx_d       = 1'b0;
                        if (tx_idx_q == 5'd0) begin
                            tx_shift_d = MOTOR_ID;
                        end else if (tx_idx_q == 5'd15) begin
                            tx_shift_d = tx_sum_q;
                        end else begin
                            tx_shift_d = tx_buf_q[7:0];
                            tx_buf_d   = tx_buf_q >> 8;
                            tx_sum_d   = tx_sum_q + tx_buf_q[7:0];
                        end
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Transmitter state register; reset drives the line idle on the next edge
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            tx_buf_q   <= '0;
            tx_sum_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
            tx_buf_q   <= tx_buf_d;
            tx_sum_q   <= tx_sum_d;
            tx_q       <= tx_d;
        end
    end

    assign tx             = tx_q;
    assign setpoint       = setpoint_q;
    assign setpoint_valid = setpoint_valid_q;
    assign frame_error    = frame_error_q;
    assign busy           = pending_q || (tx_state_q != TX_IDLE);

endmodule
